// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection (redirect / hold / +4) and the end-of-program compare.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int PROG_END = 28
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              halt,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc_next,
  output logic              at_end
);

  // One extra bit so PROG_END == 2^ADDR_W is representable and never reached.
  localparam logic [ADDR_W:0] END_ADDR = (ADDR_W + 1)'(PROG_END);

  logic unused_low;
  assign unused_low = ^br_target[1:0];

  assign at_end = ({1'b0, pc} >= END_ADDR);

  always_comb begin
    pc_next = pc;
    if (halt) begin
      pc_next = pc;
    end else if (br_taken) begin
      pc_next = {br_target[ADDR_W-1:2], 2'b00};
    end else if (stall || at_end) begin
      pc_next = pc;
    end else begin
      pc_next = pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, loads the IF/ID register, handles stall,
// redirect-with-flush and the sticky halt at the end of the program.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int INSTR_W  = 32,
  parameter int PROG_END = 28,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               br_taken_i,
  input  logic [ADDR_W-1:0]  br_target_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic               if_valid_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   fetch_cnt_o
);

  state_e            state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic              at_end;

  assign imem_addr_o = pc_q;

  fetch_pc_gen #(
    .ADDR_W   (ADDR_W),
    .PROG_END (PROG_END)
  ) u_pc_gen (
    .pc        (pc_q),
    .halt      (state == HALT),
    .stall     (stall_i),
    .br_taken  (br_taken_i),
    .br_target (br_target_i),
    .pc_next   (pc_next),
    .at_end    (at_end)
  );

  // IF/ID stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc_q        <= '0;
      if_pc_o     <= '0;
      if_instr_o  <= INSTR_W'(NOP);
      if_valid_o  <= 1'b0;
      halted_o    <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      pc_q <= pc_next;
      case (state)
        FETCH: begin
          if (br_taken_i) begin
            if_valid_o <= 1'b0;
          end else if (stall_i) begin
            if_valid_o <= if_valid_o;
          end else if (at_end) begin
            if_valid_o <= 1'b0;
            halted_o   <= 1'b1;
            state      <= HALT;
          end else begin
            if_pc_o    <= pc_q;
            if_instr_o <= imem_data_i;
            if_valid_o <= 1'b1;
            if (fetch_cnt_o != '1) fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
          end
        end
        default: begin
          if_valid_o <= 1'b0;
          halted_o   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: vector table through a scoreboard queue, plus a
// wrap-around sequence on a second instance with PROG_END = 2^ADDR_W.
module tb_fetch_ctrl;

  localparam int AW = 7;

  typedef struct {
    bit          r;
    bit          s;
    bit          b;
    logic [6:0]  t;
    bit          ev;
    logic [6:0]  ep;
    logic [31:0] ei;
    bit          eh;
    int          ec;
  } vec_t;

  typedef struct {
    bit          ev;
    logic [6:0]  ep;
    logic [31:0] ei;
    bit          eh;
    int          ec;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, br;
  logic [6:0]  tgt;
  logic [6:0]  addr;
  logic [31:0] data;
  logic [6:0]  if_pc;
  logic [31:0] if_instr;
  logic        if_valid, halted;
  logic [15:0] cnt;

  logic        rst2;
  logic [6:0]  addr2;
  logic [31:0] data2;
  logic [6:0]  if_pc2;
  logic [31:0] if_instr2;
  logic        if_valid2, halted2;
  logic [15:0] cnt2;

  logic [7:0]  mem [0:127];

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [6:0] a);
    return {mem[a], mem[a + 7'd1], mem[a + 7'd2], mem[a + 7'd3]};
  endfunction

  always_comb data  = rd(addr);
  always_comb data2 = rd(addr2);

  fetch_ctrl #(.ADDR_W(AW), .INSTR_W(32), .PROG_END(28), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .br_taken_i(br), .br_target_i(tgt),
    .imem_addr_o(addr), .imem_data_i(data), .if_pc_o(if_pc), .if_instr_o(if_instr),
    .if_valid_o(if_valid), .halted_o(halted), .fetch_cnt_o(cnt)
  );

  fetch_ctrl #(.ADDR_W(AW), .INSTR_W(32), .PROG_END(128), .CNT_W(16)) dut_wrap (
    .clk(clk), .rst(rst2), .stall_i(1'b0), .br_taken_i(1'b0), .br_target_i(7'd0),
    .imem_addr_o(addr2), .imem_data_i(data2), .if_pc_o(if_pc2), .if_instr_o(if_instr2),
    .if_valid_o(if_valid2), .halted_o(halted2), .fetch_cnt_o(cnt2)
  );

  function automatic vec_t v(input bit r, input bit s, input bit b, input int t,
                             input bit ev, input int ep, input int ei, input bit eh,
                             input int ec);
    vec_t x;
    x.r = r; x.s = s; x.b = b; x.t = 7'(t);
    x.ev = ev; x.ep = 7'(ep); x.ei = 32'(ei); x.eh = eh; x.ec = ec;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    for (int w = 0; w < 7; w++) mem[4*w + 3] = 8'(w + 1);

    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0; rst2 = 1'b1;

    // reset, then 7 free-running fetches and the halt
    vecs.push_back(v(1,0,0,0,  0, 0,0,0,0));
    for (int k = 1; k <= 7; k++) vecs.push_back(v(0,0,0,0, 1,4*(k-1),k,0,k));
    vecs.push_back(v(0,0,0,0,  0,24,7,1,7));
    // HALT ignores redirect and stall
    vecs.push_back(v(0,0,1,0,  0,24,7,1,7));
    vecs.push_back(v(0,1,0,0,  0,24,7,1,7));
    // reset from HALT
    vecs.push_back(v(1,0,0,0,  0, 0,0,0,0));
    vecs.push_back(v(0,0,0,0,  1, 0,1,0,1));
    vecs.push_back(v(0,0,0,0,  1, 4,2,0,2));
    vecs.push_back(v(0,0,0,0,  1, 8,3,0,3));
    // stall 3 cycles with if_pc=8
    for (int k = 0; k < 3; k++) vecs.push_back(v(0,1,0,0, 1,8,3,0,3));
    vecs.push_back(v(0,0,0,0,  1,12,4,0,4));
    // redirect to 4 from pc_q=16
    vecs.push_back(v(0,0,1,4,  0,12,4,0,4));
    vecs.push_back(v(0,0,0,0,  1, 4,2,0,5));
    // redirect together with stall
    vecs.push_back(v(0,1,1,0,  0, 4,2,0,5));
    vecs.push_back(v(0,0,0,0,  1, 0,1,0,6));
    // misaligned target 6 -> 4
    vecs.push_back(v(0,0,1,6,  0, 0,1,0,6));
    vecs.push_back(v(0,0,0,0,  1, 4,2,0,7));
    // reset during stall
    vecs.push_back(v(0,1,0,0,  1, 4,2,0,7));
    vecs.push_back(v(1,1,0,0,  0, 0,0,0,0));
    // run to pc_q == PROG_END, then branch on the last slot
    for (int k = 1; k <= 7; k++) vecs.push_back(v(0,0,0,0, 1,4*(k-1),k,0,k));
    vecs.push_back(v(0,0,1,8,  0,24,7,0,7));
    vecs.push_back(v(0,0,0,0,  1, 8,3,0,8));
    vecs.push_back(v(0,0,0,0,  1,12,4,0,9));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst = vecs[i].r; stall = vecs[i].s; br = vecs[i].b; tgt = vecs[i].t;
      sb.push_back('{ev: vecs[i].ev, ep: vecs[i].ep, ei: vecs[i].ei,
                     eh: vecs[i].eh, ec: vecs[i].ec});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk("if_valid", i, 32'(if_valid), 32'(e.ev));
      chk("if_pc",    i, 32'(if_pc),    32'(e.ep));
      chk("if_instr", i, if_instr,      e.ei);
      chk("halted",   i, 32'(halted),   32'(e.eh));
      chk("fetch_cnt",i, 32'(cnt),      32'(e.ec));
    end
    rst = 1'b0; stall = 1'b0; br = 1'b0;
    chk("sb_empty", 0, 32'(sb.size()), 32'd0);

    // PROG_END == 2^ADDR_W: never halts, PC wraps 124 -> 0
    @(posedge clk); #1;
    rst2 = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      if (k == 32) begin
        chk("wrap_pc_last", k, 32'(if_pc2), 32'd124);
        chk("wrap_halted",  k, 32'(halted2), 32'd0);
      end
    end
    chk("wrap_pc_zero", 33, 32'(if_pc2), 32'd0);
    chk("wrap_instr",   33, if_instr2, 32'd1);
    chk("wrap_valid",   33, 32'(if_valid2), 32'd1);
    chk("wrap_cnt",     33, 32'(cnt2), 32'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
